// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/imem_addr_chk.sv
// Byte-address legality (word aligned, inside memory) and word index.
module imem_addr_chk
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic [31:0]   addr,
  output logic          ok,
  output logic [AW-1:0] word
);

  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  assign ok   = (addr[1:0] == 2'b00) && ({1'b0, addr} < LIMIT);
  assign word = addr[AW+1:2];

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates one IMEM port between IF fetches and the program loader.
// Optional build macro IMEM_WRITE_PROTECT_EN locks out the loader after the first fetch.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  input  logic          flush,
  output logic          fetch_valid,
  output logic [31:0]   fetch_data,
  output logic          fetch_err,
  output logic          fetch_stall,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t          state_q;
  state_t          state_d;
  logic            f_ok;
  logic            l_ok;
  logic [AW-1:0]   f_word;
  logic [AW-1:0]   l_word;
  logic            lock_q;
  logic            ld_req_eff;
  logic            accept;
  logic            rsp_v_q;
  logic            rsp_err_q;
  logic            ack_q;

  imem_addr_chk #(.DEPTH(DEPTH), .AW(AW)) u_fchk (
    .addr (fetch_addr),
    .ok   (f_ok),
    .word (f_word)
  );

  imem_addr_chk #(.DEPTH(DEPTH), .AW(AW)) u_lchk (
    .addr (ld_addr),
    .ok   (l_ok),
    .word (l_word)
  );

`ifdef IMEM_WRITE_PROTECT_EN
  // Sticky until reset: once code runs, the image is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lock_q <= 1'b0;
    else if (accept) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

  assign ld_req_eff = ld_req & ~lock_q;
  assign accept     = (state_q == S_RUN) & fetch_req & ~ld_req_eff;

  always_comb begin
    state_d     = state_q;
    fetch_stall = 1'b1;
    ld_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = f_word;
    unique case (state_q)
      S_IDLE: begin
        if (ld_req_eff) state_d = S_LOAD;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        fetch_stall = ld_req_eff;
        mem_en      = accept & f_ok;
        if (ld_req_eff) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_gnt   = 1'b1;
        mem_en   = ld_req & l_ok;
        mem_we   = ld_req & l_ok;
        mem_addr = l_word;
        if (!ld_req) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_wdata = ld_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rsp_v_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_v_q   <= accept;
      rsp_err_q <= accept & ~f_ok;
      ack_q     <= (state_q == S_LOAD) & ld_req;
    end
  end

  // Read data arrives with the registered response; flush kills it.
  always_comb begin
    fetch_valid = rsp_v_q & ~flush;
    fetch_err   = 1'b0;
    fetch_data  = 32'h0;
    unique case (1'b1)
      !fetch_valid: fetch_data = 32'h0;
      rsp_err_q: begin
        fetch_err  = 1'b1;
        fetch_data = NOP;
      end
      default: fetch_data = mem_rdata;
    endcase
  end

  assign ld_ack = ack_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous read-first memory.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        fetch_stall;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_ack;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  imem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .fetch_stall (fetch_stall),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_gnt      (ld_gnt),
    .ld_ack      (ld_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    flush      = 1'b0;
    ld_req     = 1'b0;
    ld_addr    = 32'h0;
    ld_wdata   = 32'h0;
  endtask

  task automatic go_run;
    idle_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #3;
    vec++;
    if ({fetch_valid, fetch_err, ld_gnt, ld_ack, mem_en, mem_we} !== 6'b0) begin
      miss++;
      $display("FAIL reset_outs got=%b want=000000",
               {fetch_valid, fetch_err, ld_gnt, ld_ack, mem_en, mem_we});
    end
    vec++;
    if (fetch_data !== 32'h0 || fetch_stall !== 1'b1) begin
      miss++;
      $display("FAIL reset_data_stall got=%h/%b want=00000000/1",
               fetch_data, fetch_stall);
    end
    tick();
    rst_n = 1'b1;
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    #1;
    vec++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || fetch_stall !== 1'b1) begin
      miss++;
      $display("FAIL idle_no_mem got en=%b we=%b stall=%b want 0 0 1",
               mem_en, mem_we, fetch_stall);
    end
    tick();
    vec++;
    if (fetch_valid !== 1'b0) begin
      miss++;
      $display("FAIL idle_no_rsp got=%b want=0", fetch_valid);
    end
  endtask

  task automatic test_fetch;
    go_run();
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    #1;
    vec++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd2 || fetch_stall !== 1'b0) begin
      miss++;
      $display("FAIL fetch_port got en=%b we=%b a=%0d st=%b want 1 0 2 0",
               mem_en, mem_we, mem_addr, fetch_stall);
    end
    tick();
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'h00C02283 || fetch_err !== 1'b0) begin
      miss++;
      $display("FAIL fetch_rsp got v=%b d=%h e=%b want 1 00c02283 0",
               fetch_valid, fetch_data, fetch_err);
    end
    tick();
    vec++;
    if (fetch_valid !== 1'b0) begin
      miss++;
      $display("FAIL fetch_single got=%b want=0", fetch_valid);
    end
  endtask

  task automatic test_load;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    ld_req     = 1'b1;
    ld_addr    = 32'h10;
    ld_wdata   = 32'hDEADBEEF;
    #1;
    vec++;
    if (fetch_stall !== 1'b1 || mem_en !== 1'b0) begin
      miss++;
      $display("FAIL load_prio got st=%b en=%b want 1 0", fetch_stall, mem_en);
    end
    tick();
    vec++;
    if (ld_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd4 ||
        mem_wdata !== 32'hDEADBEEF || fetch_stall !== 1'b1 || fetch_valid !== 1'b0) begin
      miss++;
      $display("FAIL load_write got g=%b en=%b we=%b a=%0d d=%h st=%b v=%b want 1 1 1 4 deadbeef 1 0",
               ld_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_stall, fetch_valid);
    end
    tick();
    ld_req = 1'b0;
    #1;
    vec++;
    if (ld_ack !== 1'b1 || ld_gnt !== 1'b1 || mem_en !== 1'b0) begin
      miss++;
      $display("FAIL load_ack got ack=%b g=%b en=%b want 1 1 0", ld_ack, ld_gnt, mem_en);
    end
    tick();
    fetch_addr = 32'h10;
    #1;
    vec++;
    if (ld_ack !== 1'b0 || ld_gnt !== 1'b0 || fetch_stall !== 1'b0 || mem_addr !== 6'd4) begin
      miss++;
      $display("FAIL load_exit got ack=%b g=%b st=%b a=%0d want 0 0 0 4",
               ld_ack, ld_gnt, fetch_stall, mem_addr);
    end
    tick();
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'hDEADBEEF) begin
      miss++;
      $display("FAIL load_readback got v=%b d=%h want 1 deadbeef", fetch_valid, fetch_data);
    end
    tick();
  endtask

  task automatic test_flush;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    tick();
    flush      = 1'b1;
    fetch_addr = 32'h14;
    #1;
    vec++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 6'd5) begin
      miss++;
      $display("FAIL flush_kill got v=%b e=%b en=%b a=%0d want 0 0 1 5",
               fetch_valid, fetch_err, mem_en, mem_addr);
    end
    tick();
    flush     = 1'b0;
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'h00500093) begin
      miss++;
      $display("FAIL flush_next got v=%b d=%h want 1 00500093", fetch_valid, fetch_data);
    end
    tick();
  endtask

  task automatic test_addr_err;
    fetch_req  = 1'b1;
    fetch_addr = 32'h6;
    #1;
    vec++;
    if (mem_en !== 1'b0 || fetch_stall !== 1'b0) begin
      miss++;
      $display("FAIL misalign_port got en=%b st=%b want 0 0", mem_en, fetch_stall);
    end
    tick();
    fetch_addr = 32'h100;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_data !== 32'h00000013) begin
      miss++;
      $display("FAIL misalign_rsp got v=%b e=%b d=%h want 1 1 00000013",
               fetch_valid, fetch_err, fetch_data);
    end
    vec++;
    if (mem_en !== 1'b0) begin
      miss++;
      $display("FAIL range_port got en=%b want 0", mem_en);
    end
    tick();
    fetch_addr = 32'hFC;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_data !== 32'h00000013) begin
      miss++;
      $display("FAIL range_rsp got v=%b e=%b d=%h want 1 1 00000013",
               fetch_valid, fetch_err, fetch_data);
    end
    vec++;
    if (mem_en !== 1'b1 || mem_addr !== 6'd63) begin
      miss++;
      $display("FAIL last_word_port got en=%b a=%0d want 1 63", mem_en, mem_addr);
    end
    tick();
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== 32'h0000006F) begin
      miss++;
      $display("FAIL last_word_rsp got v=%b e=%b d=%h want 1 0 0000006f",
               fetch_valid, fetch_err, fetch_data);
    end
    tick();
  endtask

  task automatic test_drop_write;
    ld_req   = 1'b1;
    ld_addr  = 32'h41;
    ld_wdata = 32'h12345678;
    tick();
    vec++;
    if (ld_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      miss++;
      $display("FAIL drop_port got g=%b en=%b we=%b want 1 0 0", ld_gnt, mem_en, mem_we);
    end
    tick();
    ld_req = 1'b0;
    #1;
    vec++;
    if (ld_ack !== 1'b1) begin
      miss++;
      $display("FAIL drop_ack got=%b want=1", ld_ack);
    end
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h40;
    tick();
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'hA5A5A5A5) begin
      miss++;
      $display("FAIL drop_mem got v=%b d=%h want 1 a5a5a5a5", fetch_valid, fetch_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_load;
    ld_req   = 1'b1;
    ld_addr  = 32'h20;
    ld_wdata = 32'hCAFEF00D;
    tick();
    tick();
    vec++;
    if (ld_ack !== 1'b1 || ld_gnt !== 1'b1) begin
      miss++;
      $display("FAIL midload_pending got ack=%b g=%b want 1 1", ld_ack, ld_gnt);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (ld_ack !== 1'b0 || ld_gnt !== 1'b0 || fetch_stall !== 1'b1 ||
        mem_en !== 1'b0 || mem_we !== 1'b0) begin
      miss++;
      $display("FAIL midload_reset got ack=%b g=%b st=%b en=%b we=%b want 0 0 1 0 0",
               ld_ack, ld_gnt, fetch_stall, mem_en, mem_we);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    go_run();
    fetch_req  = 1'b1;
    fetch_addr = 32'h20;
    tick();
    fetch_req = 1'b0;
    #1;
    vec++;
    if (fetch_valid !== 1'b1 || fetch_data !== 32'hCAFEF00D) begin
      miss++;
      $display("FAIL midload_mem got v=%b d=%h want 1 cafef00d", fetch_valid, fetch_data);
    end
    tick();
  endtask

`ifdef IMEM_WRITE_PROTECT_EN
  task automatic test_write_protect;
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    ld_req     = 1'b1;
    ld_addr    = 32'h8;
    ld_wdata   = 32'h0;
    #1;
    vec++;
    if (fetch_stall !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      miss++;
      $display("FAIL wp_port got st=%b we=%b en=%b want 0 0 1", fetch_stall, mem_we, mem_en);
    end
    tick();
    tick();
    vec++;
    if (ld_gnt !== 1'b0 || ld_ack !== 1'b0 || fetch_valid !== 1'b1 ||
        fetch_data !== 32'h00C02283) begin
      miss++;
      $display("FAIL wp_locked got g=%b ack=%b v=%b d=%h want 0 0 1 00c02283",
               ld_gnt, ld_ack, fetch_valid, fetch_data);
    end
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00C02283;
    mem[5]  = 32'h00500093;
    mem[16] = 32'hA5A5A5A5;
    mem[63] = 32'h0000006F;
    mem_rdata = 32'h0;
    test_reset();
`ifdef IMEM_WRITE_PROTECT_EN
    test_fetch();
    test_write_protect();
    test_flush();
    test_addr_err();
`else
    test_fetch();
    test_load();
    test_flush();
    test_addr_err();
    test_drop_write();
    test_reset_mid_load();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning instruction-memory depth in words.
REQ-002 The block SHALL have parameter AW, default 6, meaning memory word-address width, equal to log2(DEPTH).
REQ-003 The block SHALL have ports clk  in  1  the single clock; rising edge.
REQ-004 The block SHALL have ports rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports start  in  1  a pulse that leaves IDLE and enables fetching.
REQ-006 The block SHALL have ports fetch_req, fetch_addr  in  1, 32  the IF-stage read request and byte PC.
REQ-007 The block SHALL have ports flush  in  1  branch/jump redirect; cancels the outstanding fetch response.
REQ-008 The block SHALL have ports fetch_valid, fetch_data, fetch_err  out  1, 32, 1  the fetch response.
REQ-009 The block SHALL have ports fetch_stall  out  1  high when fetch_req cannot be accepted this cycle.
REQ-010 The block SHALL have ports ld_req, ld_addr, ld_wdata  in  1, 32, 32  the program-loader write request.
REQ-011 The block SHALL have ports ld_gnt, ld_ack  out  1, 1  loader ownership, and a write-done pulse.
REQ-012 The block SHALL have ports mem_en, mem_we, mem_addr, mem_wdata  out  1, 1, AW, 32  the memory port.
REQ-013 The block SHALL have ports mem_rdata  in  32  synchronous read data, valid one cycle after mem_en.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and LOAD.
REQ-015 IDLE SHALL go to LOAD on ld_req, else to RUN on start; ld_req wins when both are asserted.
REQ-016 RUN SHALL go to LOAD on ld_req; the loader has priority over fetch.
REQ-017 LOAD SHALL go to RUN one cycle after ld_req deasserts.
REQ-018 In RUN, fetch_req with no ld_req SHALL drive mem_en=1, mem_we=0 and mem_addr=fetch_addr[AW+1:2] in the same cycle.
REQ-019 fetch_valid and fetch_data SHALL be asserted exactly one cycle after an accepted fetch.
REQ-020 fetch_stall SHALL be 1 in IDLE, in LOAD, and in RUN whenever ld_req is asserted.
REQ-021 A fetch response outstanding at a RUN->LOAD transition SHALL still be delivered in the first LOAD cycle.
REQ-022 flush SHALL force fetch_valid=0 for a response due in the next cycle; a fetch_req in the same cycle as flush SHALL be accepted normally.
REQ-023 A fetch with fetch_addr[1:0]!=0 SHALL produce fetch_err=1, fetch_valid=1 and fetch_data=32'h00000013 one cycle later, with no mem_en.
REQ-024 A fetch with fetch_addr>=DEPTH*4 SHALL produce fetch_err=1, fetch_valid=1 and fetch_data=32'h00000013 one cycle later, with no mem_en.
REQ-025 In LOAD, ld_gnt SHALL be 1.
REQ-026 In LOAD, each cycle with ld_req=1 SHALL drive mem_en=1, mem_we=1, mem_addr=ld_addr[AW+1:2] and mem_wdata=ld_wdata.
REQ-027 ld_ack SHALL pulse one cycle after each loader write.
REQ-028 A loader write to a misaligned or out-of-range address SHALL be dropped (mem_en=0) but SHALL still be acked.
REQ-029 mem_en and mem_we SHALL never be asserted in IDLE.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force state IDLE and set fetch_valid, fetch_err, fetch_data, ld_gnt, ld_ack, mem_en and mem_we to 0, with fetch_stall=1.
REQ-031 Reset mid-LOAD SHALL discard the pending ack; memory contents SHALL be unaffected by reset.

Configuration
REQ-032 When IMEM_WRITE_PROTECT_EN is defined, the first accepted fetch after reset SHALL set a sticky lock bit.
REQ-033 While the lock bit is set, ld_req SHALL be ignored: the FSM stays in RUN, ld_gnt=0, ld_ack=0, and fetch_stall follows RUN rules only.
REQ-034 The lock bit SHALL be cleared only by reset.
REQ-035 When IMEM_WRITE_PROTECT_EN is undefined, no lock bit SHALL exist and loading SHALL always be permitted.

Structure
REQ-036 The FSM state enum, the NOP constant 32'h00000013, and DEPTH/AW defaults SHALL live in the shared package imem_pkg.
REQ-037 Address legality checking (alignment and range) SHALL be one sub-module, imem_addr_chk, instantiated for both the fetch and loader paths.

Verification
REQ-038 Reset, then start, then fetch_addr=0x8 with mem_rdata=0x00C02283 -> mem_addr=2 the same cycle; fetch_valid=1 and fetch_data=0x00C02283 the next cycle.
REQ-039 ld_req together with fetch_req in RUN -> fetch_stall=1; LOAD entered; ld_addr=0x10, ld_wdata=0xDEADBEEF gives mem_addr=4, mem_we=1, and ld_ack the next cycle.
REQ-040 flush in the cycle after a fetch of 0x4 -> fetch_valid=0; a simultaneous fetch of 0x14 is returned the next cycle.
REQ-041 fetch_addr=0x6 -> fetch_err=1 and fetch_data=0x00000013; fetch_addr=0x100 (DEPTH=64) -> fetch_err=1 with mem_en=0.
REQ-042 rst_n low during a LOAD write -> ld_ack=0 and state IDLE immediately; after release, the previously written word reads back unchanged.
REQ-043 With IMEM_WRITE_PROTECT_EN defined, one fetch then ld_req -> ld_gnt stays 0, no mem_we, and fetching continues.
